// File: rtl/if_id_fetch_stage.sv
// Fetch stage and IF/ID pipeline register with opcode/register pre-decode.
// Obeys the hazard unit's stall, squashes on taken branches, parks on HALT.
module if_id_fetch_stage #(
    parameter int unsigned          PC_WIDTH    = 8,
    parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0,
    parameter logic [3:0]           HALT_OPCODE = 4'b1111
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                mux_enable,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [15:0]         imem_rdata,
    output logic [15:0]         IF_ID_instr,
    output logic [PC_WIDTH-1:0] IF_ID_pc,
    output logic [3:0]          IF_ID_opcode,
    output logic [2:0]          IF_ID_dest,
    output logic [2:0]          IF_ID_src1,
    output logic [2:0]          IF_ID_src2,
    output logic                Valid_out_IF_ID,
    output logic                halted,
    output logic [15:0]         stall_count
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [PC_WIDTH-1:0]  pc_q, pc_d;
    logic [15:0]          instr_q, instr_d;
    logic [PC_WIDTH-1:0]  ifid_pc_q, ifid_pc_d;
    logic                 valid_q, valid_d;
    logic [15:0]          stall_cnt_q, stall_cnt_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            instr_q     <= '0;
            ifid_pc_q   <= '0;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            ifid_pc_q   <= ifid_pc_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        ifid_pc_d   = ifid_pc_q;
        valid_d     = valid_q;
        stall_cnt_d = stall_cnt_q;
        if (branch_taken) begin
            // Redirect wins over a stall and is the only way out of HALT
            pc_d    = branch_target;
            valid_d = 1'b0;
            state_d = RUN;
        end else if (!mux_enable) begin
            if (stall_cnt_q != 16'hFFFF) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
        end else begin
            unique case (state_q)
                RUN: begin
                    instr_d   = imem_rdata;
                    ifid_pc_d = pc_q;
                    valid_d   = 1'b1;
                    if (imem_rdata[15:12] == HALT_OPCODE) begin
                        state_d = HALT;
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                end
                HALT: begin
                    valid_d = 1'b0;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    assign imem_addr       = pc_q;
    assign IF_ID_instr     = instr_q;
    assign IF_ID_pc        = ifid_pc_q;
    assign IF_ID_opcode    = instr_q[15:12];
    assign IF_ID_dest      = instr_q[11:9];
    assign IF_ID_src1      = instr_q[8:6];
    assign IF_ID_src2      = instr_q[5:3];
    assign Valid_out_IF_ID = valid_q;
    assign halted          = (state_q == HALT);
    assign stall_count     = stall_cnt_q;

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Directed bench for if_id_fetch_stage with a combinational imem model.
module tb_if_id_fetch_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        mux_enable;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic [15:0] IF_ID_instr;
    logic [7:0]  IF_ID_pc;
    logic [3:0]  IF_ID_opcode;
    logic [2:0]  IF_ID_dest;
    logic [2:0]  IF_ID_src1;
    logic [2:0]  IF_ID_src2;
    logic        Valid_out_IF_ID;
    logic        halted;
    logic [15:0] stall_count;

    logic [15:0] mem [0:255];
    int          passed = 0;
    int          total  = 0;

    always #5 clock = ~clock;

    assign imem_rdata = mem[imem_addr];

    if_id_fetch_stage #(
        .PC_WIDTH    (8),
        .RESET_PC    (8'h00),
        .HALT_OPCODE (4'b1111)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .mux_enable      (mux_enable),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .IF_ID_instr     (IF_ID_instr),
        .IF_ID_pc        (IF_ID_pc),
        .IF_ID_opcode    (IF_ID_opcode),
        .IF_ID_dest      (IF_ID_dest),
        .IF_ID_src1      (IF_ID_src1),
        .IF_ID_src2      (IF_ID_src2),
        .Valid_out_IF_ID (Valid_out_IF_ID),
        .halted          (halted),
        .stall_count     (stall_count)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        mux_enable    = 1'b1;
        branch_taken  = 1'b0;
        branch_target = 8'h00;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        mux_enable    = 1'b1;
        branch_taken  = 1'b0;
        branch_target = 8'h00;
        step();
        step();
        total++;
        if ({Valid_out_IF_ID, halted, imem_addr, IF_ID_pc, IF_ID_instr, stall_count}
            !== {1'b0, 1'b0, 8'h00, 8'h00, 16'h0000, 16'h0000})
            $display("FAIL reset_state: v=%0b h=%0b addr=%h pc=%h ins=%h sc=%0d want all zero",
                     Valid_out_IF_ID, halted, imem_addr, IF_ID_pc, IF_ID_instr, stall_count);
        else passed++;
        total++;
        if ({IF_ID_opcode, IF_ID_dest, IF_ID_src1, IF_ID_src2} !== 13'd0)
            $display("FAIL reset_fields: got %h/%h/%h/%h want 0", IF_ID_opcode,
                     IF_ID_dest, IF_ID_src1, IF_ID_src2);
        else passed++;
        reset = 1'b0;
    endtask

    task automatic test_pipeline();
        logic [15:0] exp_ins [0:2];
        logic [12:0] exp_fld [0:2];
        exp_ins[0] = 16'h0298; exp_fld[0] = {4'h0, 3'd1, 3'd2, 3'd3};
        exp_ins[1] = 16'h1970; exp_fld[1] = {4'h1, 3'd4, 3'd5, 3'd6};
        exp_ins[2] = 16'h2E08; exp_fld[2] = {4'h2, 3'd7, 3'd0, 3'd1};
        do_reset();
        total++;
        if (Valid_out_IF_ID !== 1'b0 || imem_addr !== 8'h00)
            $display("FAIL first_cycle: v=%0b addr=%h want v=0 addr=00",
                     Valid_out_IF_ID, imem_addr);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (IF_ID_pc !== 8'(i) || IF_ID_instr !== exp_ins[i] || Valid_out_IF_ID !== 1'b1
                || imem_addr !== 8'(i + 1))
                $display("FAIL seq_%0d: pc=%h ins=%h v=%0b addr=%h want pc=%h ins=%h v=1 addr=%h",
                         i, IF_ID_pc, IF_ID_instr, Valid_out_IF_ID, imem_addr,
                         8'(i), exp_ins[i], 8'(i + 1));
            else passed++;
            total++;
            if ({IF_ID_opcode, IF_ID_dest, IF_ID_src1, IF_ID_src2} !== exp_fld[i])
                $display("FAIL fields_%0d: got %h/%h/%h/%h want %h", i, IF_ID_opcode,
                         IF_ID_dest, IF_ID_src1, IF_ID_src2, exp_fld[i]);
            else passed++;
        end
    endtask

    task automatic test_halt();
        step();
        total++;
        if (IF_ID_opcode !== 4'hF || Valid_out_IF_ID !== 1'b1 || IF_ID_pc !== 8'h03
            || imem_addr !== 8'h03)
            $display("FAIL halt_latch: op=%h v=%0b pc=%h addr=%h want op=f v=1 pc=03 addr=03",
                     IF_ID_opcode, Valid_out_IF_ID, IF_ID_pc, imem_addr);
        else passed++;
        step();
        step();
        total++;
        if (Valid_out_IF_ID !== 1'b0 || halted !== 1'b1 || imem_addr !== 8'h03
            || IF_ID_instr !== 16'hF000)
            $display("FAIL halted: v=%0b h=%0b addr=%h ins=%h want v=0 h=1 addr=03 ins=f000",
                     Valid_out_IF_ID, halted, imem_addr, IF_ID_instr);
        else passed++;
        branch_taken  = 1'b1;
        branch_target = 8'h00;
        step();
        branch_taken = 1'b0;
        total++;
        if (halted !== 1'b0 || Valid_out_IF_ID !== 1'b0 || imem_addr !== 8'h00)
            $display("FAIL halt_exit: h=%0b v=%0b addr=%h want h=0 v=0 addr=00",
                     halted, Valid_out_IF_ID, imem_addr);
        else passed++;
        step();
        total++;
        if (IF_ID_pc !== 8'h00 || Valid_out_IF_ID !== 1'b1 || IF_ID_instr !== 16'h0298)
            $display("FAIL halt_resume: pc=%h v=%0b ins=%h want pc=00 v=1 ins=0298",
                     IF_ID_pc, Valid_out_IF_ID, IF_ID_instr);
        else passed++;
    endtask

    task automatic test_stall();
        do_reset();
        branch_taken  = 1'b1;
        branch_target = 8'h05;
        step();
        branch_taken = 1'b0;
        step();
        mux_enable = 1'b0;
        repeat (3) step();
        total++;
        if (IF_ID_pc !== 8'h05 || imem_addr !== 8'h06 || stall_count !== 16'd3
            || Valid_out_IF_ID !== 1'b1 || IF_ID_instr !== 16'h3123)
            $display("FAIL stall_hold: pc=%h addr=%h sc=%0d v=%0b ins=%h want 05 06 3 1 3123",
                     IF_ID_pc, imem_addr, stall_count, Valid_out_IF_ID, IF_ID_instr);
        else passed++;
        mux_enable = 1'b1;
        step();
        total++;
        if (IF_ID_pc !== 8'h06 || IF_ID_instr !== 16'h4456 || stall_count !== 16'd3)
            $display("FAIL stall_release: pc=%h ins=%h sc=%0d want pc=06 ins=4456 sc=3",
                     IF_ID_pc, IF_ID_instr, stall_count);
        else passed++;
    endtask

    task automatic test_branch_in_stall();
        mux_enable    = 1'b0;
        step();
        total++;
        if (stall_count !== 16'd4)
            $display("FAIL stall_count4: got %0d want 4", stall_count);
        else passed++;
        branch_taken  = 1'b1;
        branch_target = 8'h40;
        step();
        branch_taken = 1'b0;
        mux_enable   = 1'b1;
        total++;
        if (Valid_out_IF_ID !== 1'b0 || imem_addr !== 8'h40 || stall_count !== 16'd4
            || IF_ID_pc !== 8'h06)
            $display("FAIL branch_squash: v=%0b addr=%h sc=%0d pc=%h want v=0 addr=40 sc=4 pc=06",
                     Valid_out_IF_ID, imem_addr, stall_count, IF_ID_pc);
        else passed++;
        step();
        total++;
        if (IF_ID_pc !== 8'h40 || Valid_out_IF_ID !== 1'b1 || imem_addr !== 8'h41)
            $display("FAIL branch_target: pc=%h v=%0b addr=%h want pc=40 v=1 addr=41",
                     IF_ID_pc, Valid_out_IF_ID, imem_addr);
        else passed++;
    endtask

    task automatic test_wrap();
        branch_taken  = 1'b1;
        branch_target = 8'hFF;
        step();
        branch_taken = 1'b0;
        step();
        total++;
        if (IF_ID_pc !== 8'hFF || imem_addr !== 8'h00 || IF_ID_instr !== 16'h1234)
            $display("FAIL pc_wrap: pc=%h addr=%h ins=%h want pc=ff addr=00 ins=1234",
                     IF_ID_pc, imem_addr, IF_ID_instr);
        else passed++;
    endtask

    task automatic test_reset_in_halt();
        do_reset();
        branch_taken  = 1'b1;
        branch_target = 8'h03;
        step();
        branch_taken = 1'b0;
        step();
        mux_enable = 1'b0;
        repeat (7) step();
        total++;
        if (halted !== 1'b1 || stall_count !== 16'd7)
            $display("FAIL pre_reset: h=%0b sc=%0d want h=1 sc=7", halted, stall_count);
        else passed++;
        reset         = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 8'h40;
        step();
        reset        = 1'b0;
        branch_taken = 1'b0;
        total++;
        if ({Valid_out_IF_ID, halted, imem_addr, IF_ID_pc, IF_ID_instr, stall_count}
            !== {1'b0, 1'b0, 8'h00, 8'h00, 16'h0000, 16'h0000})
            $display("FAIL reset_halt: v=%0b h=%0b addr=%h pc=%h ins=%h sc=%0d want all zero",
                     Valid_out_IF_ID, halted, imem_addr, IF_ID_pc, IF_ID_instr, stall_count);
        else passed++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0]    = 16'h0298;
        mem[1]    = 16'h1970;
        mem[2]    = 16'h2E08;
        mem[3]    = 16'hF000;
        mem[5]    = 16'h3123;
        mem[6]    = 16'h4456;
        mem[8'hFF] = 16'h1234;
        test_reset();
        test_pipeline();
        test_halt();
        test_stall();
        test_branch_in_stall();
        test_wrap();
        test_reset_in_halt();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/if_id_fetch_stage.md
Name: if_id_fetch_stage

Overview:
- Fetch stage plus IF/ID pipeline register, directly upstream of the load-use hazard detector and the ID/RF stage.
- Holds the PC and drives the instruction-memory address. Latches the fetched 16-bit instruction and pre-decodes the opcode, dest, src1 and src2 fields for the hazard unit.
- Honours the hazard unit's stall (mux_enable low), squashes on taken branches, and stops fetching on HALT.

Parameters:
- PC_WIDTH, 8, width of PC and instruction-memory address.
- RESET_PC, 0, PC value after reset.
- HALT_OPCODE, 4'b1111, opcode that stops fetching.

Ports:
- clock  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- mux_enable  input  1  from hazard unit; 1 = advance, 0 = stall (hold PC and IF/ID).
- branch_taken  input  1  redirect request from a downstream stage.
- branch_target  input  PC_WIDTH  redirect PC, valid when branch_taken=1.
- imem_addr  output  PC_WIDTH  instruction-memory address; combinational, equals pc.
- imem_rdata  input  16  instruction word; combinational read of imem_addr, same cycle.
- IF_ID_instr  output  16  latched instruction.
- IF_ID_pc  output  PC_WIDTH  PC of latched instruction.
- IF_ID_opcode  output  4  IF_ID_instr[15:12].
- IF_ID_dest  output  3  IF_ID_instr[11:9].
- IF_ID_src1  output  3  IF_ID_instr[8:6].
- IF_ID_src2  output  3  IF_ID_instr[5:3].
- Valid_out_IF_ID  output  1  IF/ID holds a live instruction.
- halted  output  1  state is HALT.
- stall_count  output  16  saturating count of stall cycles.

Behaviour:
- Reset (synchronous, priority over everything):
  - pc=RESET_PC; IF_ID_instr=0; IF_ID_pc=0; Valid_out_IF_ID=0; stall_count=0; state=RUN; halted=0.
  - Decoded fields are 0 because they are wired from IF_ID_instr.
  - Reset asserted mid-stall, mid-HALT or together with branch_taken still wins and applies exactly these values.
- Every cycle applies exactly one case, in priority order: reset > branch_taken > stall (mux_enable=0) > state action.
- branch_taken=1:
  - pc<=branch_target; Valid_out_IF_ID<=0 (squash).
  - IF_ID_instr and IF_ID_pc hold their values.
  - state<=RUN, which also leaves HALT.
  - Applies even when mux_enable=0; stall_count does not increment that cycle.
- Stall (mux_enable=0, no branch):
  - pc, IF_ID_instr, IF_ID_pc and Valid_out_IF_ID hold.
  - stall_count<=stall_count+1, saturating at 16'hFFFF.
  - state holds.
- RUN state, advance:
  - IF_ID_instr<=imem_rdata; IF_ID_pc<=pc; Valid_out_IF_ID<=1.
  - If imem_rdata[15:12]==HALT_OPCODE: the HALT instruction is latched valid, pc holds, state<=HALT.
  - Otherwise pc<=pc+1, wrapping modulo 2^PC_WIDTH (all-ones wraps to 0).
- HALT state, advance:
  - Valid_out_IF_ID<=0 (bubbles); pc and IF_ID_instr hold.
  - halted=1, decoded combinationally from state.
  - Only a taken branch or reset leaves HALT.
- Latency: an instruction at address A appears on IF_ID_* one cycle after pc==A with mux_enable=1.
- imem_addr follows pc combinationally, with no extra register.
- The stage never generates a stall itself; it obeys mux_enable only.

Test Plan:
- Reset, then imem holds opcodes 0000/0001/0010 at addresses 0..2, mux_enable=1 -> Valid_out_IF_ID=0 in the first cycle after reset. Then IF_ID_pc=0,1,2 on consecutive cycles with matching fields, and imem_addr advances 0,1,2,3.
- mux_enable=0 for 3 cycles while IF_ID holds instr at pc=5 -> IF_ID_pc stays 5, imem_addr stays 6, stall_count=3. Release -> pc=6 latched next cycle.
- branch_taken=1 with branch_target=8'h40 while mux_enable=0 -> next cycle Valid_out_IF_ID=0, imem_addr=8'h40, stall_count unchanged. Following cycle IF_ID_pc=8'h40, valid=1.
- PC_WIDTH=8, pc=8'hFF, normal instruction -> pc wraps to 8'h00, IF_ID_pc=8'hFF.
- HALT opcode fetched at pc=3 -> IF_ID_opcode=4'b1111 valid for one cycle, then valid=0 and halted=1, imem_addr stays 3. branch_taken with target 0 -> halted=0, fetch resumes at 0.
- reset asserted during HALT with stall_count=7 -> next cycle all outputs at reset values, halted=0, stall_count=0.
